// File: rtl/mcu_reg_bridge_pkg.sv
// Shared definitions for the MCU SPI-to-register-bus bridge.
//   CMD_RW_BIT : position of the read/write flag in the command byte
//   CMD_BITS   : length of the command phase in SPI bits
//   WORD_BITS  : length of one data word in SPI bits
//   state_e    : bridge FSM states
package mcu_reg_bridge_pkg;

  localparam int unsigned CMD_RW_BIT = 7;
  localparam int unsigned CMD_BITS   = 8;
  localparam int unsigned WORD_BITS  = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } state_e;

endpackage

// File: rtl/mcu_reg_bridge_spi_sync_edge.sv
// SPI pin synchroniser and edge detector for mcu_reg_bridge.
// Ports:
//   clk, reset   : system clock, synchronous active-high reset
//   sclk_i       : async SPI clock
//   cs_n_i       : async chip select, active low
//   mosi_i       : async serial data in
//   rise_o       : one-clk pulse on a synchronised SCLK rising edge
//   fall_o       : one-clk pulse on a synchronised SCLK falling edge
//   cs_active_o  : synchronised chip select is active
//   mosi_o       : synchronised MOSI, aligned with rise_o
// SYNC_STAGES must be 2 or more.
module mcu_reg_bridge_spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sclk_i,
  input  logic cs_n_i,
  input  logic mosi_i,
  output logic rise_o,
  output logic fall_o,
  output logic cs_active_o,
  output logic mosi_o
);

  logic [SYNC_STAGES-1:0] sclk_q;
  logic [SYNC_STAGES-1:0] cs_n_q;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic                   sclk_d_q;

  // The CS chain resets to "active" so that the bridge only arms once it has
  // observed a real inactive CS after reset; a frame already in flight when
  // reset releases is therefore never picked up half-way.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_q   <= '0;
      cs_n_q   <= '0;
      mosi_q   <= '0;
      sclk_d_q <= 1'b0;
    end else begin
      sclk_q   <= {sclk_q[SYNC_STAGES-2:0], sclk_i};
      cs_n_q   <= {cs_n_q[SYNC_STAGES-2:0], cs_n_i};
      mosi_q   <= {mosi_q[SYNC_STAGES-2:0], mosi_i};
      sclk_d_q <= sclk_q[SYNC_STAGES-1];
    end
  end

  assign rise_o      =  sclk_q[SYNC_STAGES-1] & ~sclk_d_q;
  assign fall_o      = ~sclk_q[SYNC_STAGES-1] &  sclk_d_q;
  assign cs_active_o = ~cs_n_q[SYNC_STAGES-1];
  assign mosi_o      =  mosi_q[SYNC_STAGES-1];

endmodule

// File: rtl/mcu_reg_bridge.sv
// SPI-slave (mode 0) to register-bus initiator.
// Frame: command byte {rw, 1'b0, addr[5:0]} then a burst of 32-bit words,
// MSB first; rw=1 reads. Address auto-increments by 4 per word and wraps.
// Ports:
//   clk, reset          : system clock (>= 8x SCLK), sync active-high reset
//   spi_sclk/cs_n/mosi  : async SPI inputs
//   spi_miso, _oe       : serial read data and its output enable
//   reg_addr            : register byte address (bits 1:0 always 0)
//   reg_wdata           : write data
//   reg_wstrobe         : one-clk write pulse
//   reg_rdata           : combinational read data for reg_addr
//   busy                : a transaction is open
// Build option: define MCU_BRIDGE_WCOUNT_EN to add an 8-bit completed-write
// counter that is shifted out on MISO during the command phase.
module mcu_reg_bridge
  import mcu_reg_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_sclk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_wstrobe,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              busy
);

  logic rise, fall, cs_active, mosi_s;

  mcu_reg_bridge_spi_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_spi_sync_edge (
    .clk         (clk),
    .reset       (reset),
    .sclk_i      (spi_sclk),
    .cs_n_i      (spi_cs_n),
    .mosi_i      (spi_mosi),
    .rise_o      (rise),
    .fall_o      (fall),
    .cs_active_o (cs_active),
    .mosi_o      (mosi_s)
  );

  state_e            state_q;
  logic [4:0]        bitcnt_q;
  logic [DATA_W-2:0] rx_q;
  logic [DATA_W-1:0] tx_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              wstrobe_q;
  logic              rw_q;
  logic              adv_pend_q;
  logic              cap_pend_q;
  logic              armed_q;
  logic              miso_q;
  logic              miso_oe_q;
  logic              busy_q;
`ifdef MCU_BRIDGE_WCOUNT_EN
  logic [7:0]        wcount_q;
`endif

  // The end-of-word address increment is deferred one clk so that reg_addr
  // still shows the written register while reg_wstrobe is high; a read then
  // captures the next word one clk after the increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      bitcnt_q   <= '0;
      rx_q       <= '0;
      tx_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrobe_q  <= 1'b0;
      rw_q       <= 1'b0;
      adv_pend_q <= 1'b0;
      cap_pend_q <= 1'b0;
      armed_q    <= 1'b0;
      miso_q     <= 1'b0;
      miso_oe_q  <= 1'b0;
      busy_q     <= 1'b0;
`ifdef MCU_BRIDGE_WCOUNT_EN
      wcount_q   <= '0;
`endif
    end else begin
      wstrobe_q <= 1'b0;

`ifdef MCU_BRIDGE_WCOUNT_EN
      if (wstrobe_q) begin
        wcount_q <= wcount_q + 8'd1;
      end
`endif

      if (cap_pend_q) begin
        tx_q       <= reg_rdata;
        cap_pend_q <= 1'b0;
      end

      if (adv_pend_q) begin
        addr_q     <= addr_q + ADDR_W'(4);
        adv_pend_q <= 1'b0;
        cap_pend_q <= rw_q;
      end

      if (!cs_active) begin
        // Deassert wins over a coincident edge; partial words are dropped.
        state_q   <= IDLE;
        bitcnt_q  <= '0;
        miso_q    <= 1'b0;
        miso_oe_q <= 1'b0;
        busy_q    <= 1'b0;
        armed_q   <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            if (armed_q) begin
              state_q   <= CMD;
              bitcnt_q  <= '0;
              rx_q      <= '0;
              miso_q    <= 1'b0;
              miso_oe_q <= 1'b1;
              busy_q    <= 1'b1;
`ifdef MCU_BRIDGE_WCOUNT_EN
              tx_q      <= {wcount_q, {(DATA_W-8){1'b0}}};
`else
              tx_q      <= '0;
`endif
            end
          end

          CMD: begin
            if (rise) begin
              rx_q     <= {rx_q[DATA_W-3:0], mosi_s};
              bitcnt_q <= bitcnt_q + 5'd1;
              if (bitcnt_q == 5'(CMD_BITS - 1)) begin
                // rx_q[6:0] holds command bits 7..1 at this point.
                rw_q       <= rx_q[CMD_RW_BIT-1];
                addr_q     <= ADDR_W'({rx_q[4:1], 2'b00});
                cap_pend_q <= rx_q[CMD_RW_BIT-1];
                state_q    <= DATA;
                bitcnt_q   <= '0;
              end
            end
`ifdef MCU_BRIDGE_WCOUNT_EN
            else if (fall) begin
              miso_q <= tx_q[DATA_W-1];
              tx_q   <= {tx_q[DATA_W-2:0], 1'b0};
            end
`endif
          end

          DATA: begin
            if (rise) begin
              rx_q     <= {rx_q[DATA_W-3:0], mosi_s};
              bitcnt_q <= bitcnt_q + 5'd1;
              if (bitcnt_q == 5'(WORD_BITS - 1)) begin
                bitcnt_q   <= '0;
                adv_pend_q <= 1'b1;
                if (!rw_q) begin
                  wdata_q   <= {rx_q, mosi_s};
                  wstrobe_q <= 1'b1;
                end
              end
            end else if (fall) begin
              miso_q <= tx_q[DATA_W-1];
              tx_q   <= {tx_q[DATA_W-2:0], 1'b0};
            end
          end

          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = miso_oe_q;
  assign reg_addr    = addr_q;
  assign reg_wdata   = wdata_q;
  assign reg_wstrobe = wstrobe_q;
  assign busy        = busy_q;

endmodule
